// File: rtl/d4seg_scanner.sv
`default_nettype none
// ============================================================================
// d4seg_scanner : 4-digit multiplexed 7-segment scan driver with per-frame
//                 snapshot and a one-cycle blanking gap at the start of each slot.
// Option macro  : D4SEG_LZB_EN enables leading-zero blanking.
// Revision      : 1.0
// ============================================================================
module d4seg_scanner #(
    parameter int PRESCALE = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ABCD1,
    input  logic [3:0] ABCD2,
    input  logic [3:0] ABCD3,
    input  logic [3:0] ABCD4,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       FRAME
);

    localparam int         c_CNT_W = $clog2(PRESCALE);
    localparam logic [1:0] c_DIG1  = 2'd0;
    localparam logic [1:0] c_DIG2  = 2'd1;
    localparam logic [1:0] c_DIG3  = 2'd2;
    localparam logic [1:0] c_DIG4  = 2'd3;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [15:0]        r_snap;
    logic               w_wrap;
    logic               w_capture;
    logic               w_lz_blank;
    logic [3:0]         w_digit;
    logic [3:0]         w_onehot;
    logic [3:0]         w_an_nxt;
    logic [6:0]         w_seg_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b1111110;
            4'd1:    f_decode = 7'b0110000;
            4'd2:    f_decode = 7'b1101101;
            4'd3:    f_decode = 7'b1111001;
            4'd4:    f_decode = 7'b0110011;
            4'd5:    f_decode = 7'b1011011;
            4'd6:    f_decode = 7'b1011111;
            4'd7:    f_decode = 7'b1110000;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1111011;
            default: f_decode = 7'b0000001;
        endcase
    endfunction

    assign w_wrap    = (r_cnt == c_CNT_W'(PRESCALE - 1));
    assign w_capture = (r_state == c_DIG1) && (r_cnt == '0);

    // State register and slot counter; wrap and advance share the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_DIG1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = c_DIG1;
        case (r_state)
            c_DIG1:  w_state_nxt = w_wrap ? c_DIG2 : c_DIG1;
            c_DIG2:  w_state_nxt = w_wrap ? c_DIG3 : c_DIG2;
            c_DIG3:  w_state_nxt = w_wrap ? c_DIG4 : c_DIG3;
            c_DIG4:  w_state_nxt = w_wrap ? c_DIG1 : c_DIG4;
            default: w_state_nxt = c_DIG1;
        endcase
    end

`ifdef D4SEG_LZB_EN
    logic w_lz1;
    logic w_lz2;
    logic w_lz3;
    assign w_lz1      = (r_snap[15:12] == 4'd0);
    assign w_lz2      = w_lz1 && (r_snap[11:8] == 4'd0);
    assign w_lz3      = w_lz2 && (r_snap[7:4] == 4'd0);
    assign w_lz_blank = ((r_state == c_DIG1) && w_lz1) ||
                        ((r_state == c_DIG2) && w_lz2) ||
                        ((r_state == c_DIG3) && w_lz3);
`else
    assign w_lz_blank = 1'b0;
`endif

    always_comb begin
        w_digit  = r_snap[15:12];
        w_onehot = 4'b1000;
        case (r_state)
            c_DIG1:  begin w_digit = r_snap[15:12]; w_onehot = 4'b1000; end
            c_DIG2:  begin w_digit = r_snap[11:8];  w_onehot = 4'b0100; end
            c_DIG3:  begin w_digit = r_snap[7:4];   w_onehot = 4'b0010; end
            c_DIG4:  begin w_digit = r_snap[3:0];   w_onehot = 4'b0001; end
            default: begin w_digit = r_snap[15:12]; w_onehot = 4'b1000; end
        endcase
    end

    // Cycle 0 of every slot is the anti-ghosting gap.
    always_comb begin
        w_an_nxt  = 4'b0000;
        w_seg_nxt = 7'b0000000;
        if ((r_cnt != '0) && !w_lz_blank) begin
            w_an_nxt  = w_onehot;
            w_seg_nxt = f_decode(w_digit);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_snap <= 16'h0000;
            AN     <= 4'b0000;
            SEG    <= 7'b0000000;
            FRAME  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_snap <= {ABCD1, ABCD2, ABCD3, ABCD4};
            end
            AN    <= w_an_nxt;
            SEG   <= w_seg_nxt;
            FRAME <= w_capture;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_d4seg_scanner.sv
`default_nettype none
// ============================================================================
// tb_d4seg_scanner : scoreboard bench; a frame-position model predicts each
//                    cycle's AN/SEG/FRAME, a monitor compares at negedge.
// Revision         : 1.0
// ============================================================================
module tb_d4seg_scanner;

    localparam int P     = 4;
    localparam int FRLEN = 4 * P;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ABCD1 = 4'd0;
    logic [3:0] ABCD2 = 4'd0;
    logic [3:0] ABCD3 = 4'd0;
    logic [3:0] ABCD4 = 4'd0;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       FRAME;

    d4seg_scanner #(.PRESCALE(P)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .ABCD1 (ABCD1),
        .ABCD2 (ABCD2),
        .ABCD3 (ABCD3),
        .ABCD4 (ABCD4),
        .SEG   (SEG),
        .AN    (AN),
        .FRAME (FRAME)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fr;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [6:0] DEC [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
                             7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};

    // Model state: frame position of the cycle being driven and the held digits.
    int         mpos = 0;
    logic [3:0] msnap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    always @(posedge CLK) cyc++;

    function automatic bit lz_blanked(input int slot);
        bit b;
        b = 1'b0;
`ifdef D4SEG_LZB_EN
        if (slot < 3) begin
            b = 1'b1;
            for (int k = 0; k <= slot; k++)
                if (msnap[k] != 4'd0) b = 1'b0;
        end
`endif
        return b;
    endfunction

    task automatic step(input logic rst, input logic [15:0] d);
        exp_t e;
        int   slot;
        int   c;
        @(posedge CLK);
        #1;
        RST = rst;
        {ABCD1, ABCD2, ABCD3, ABCD4} = d;
        e.cyc = cyc + 1;
        e.an  = 4'b0000;
        e.seg = 7'b0000000;
        e.fr  = 1'b0;
        if (rst) begin
            mpos = 0;
        end else begin
            if (mpos == 0) begin
                msnap[0] = d[15:12];
                msnap[1] = d[11:8];
                msnap[2] = d[7:4];
                msnap[3] = d[3:0];
            end
            slot = mpos / P;
            c    = mpos % P;
            e.fr = (mpos == 0);
            if (c != 0 && !lz_blanked(slot)) begin
                e.an  = 4'b1000 >> slot;
                e.seg = DEC[msnap[slot]];
            end
            mpos = (mpos + 1) % FRLEN;
        end
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic [15:0] d);
        repeat (n) step(1'b0, d);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    endtask

    function automatic logic [3:0] rnd_digit();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 4'd0;
        if (r == 9) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    always @(negedge CLK) begin : p_mon
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_checks++;
            $display("FAIL stale_expect cyc=%0d got=unchecked want_cyc=%0d", cyc, e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("AN",    {4'd0, AN},    {4'd0, e.an});
            chk("SEG",   {1'b0, SEG},   {1'b0, e.seg});
            chk("FRAME", {7'd0, FRAME}, {7'd0, e.fr});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        int          len;
        repeat (3) step(1'b1, 16'($urandom));
        run(48, 16'h1234);
        run(6, 16'h1234);
        run(26, 16'h5678);
        run(32, 16'h12C4);
        run(10, 16'h1234);
        step(1'b1, 16'h9876);
        run(32, 16'h9876);
        run(32, 16'h0047);
        run(32, 16'h0000);
        run(32, 16'h0500);
        for (int k = 0; k < 40; k++) begin
            d   = {rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit()};
            len = $urandom_range(1, 24);
            repeat (len) begin
                if ($urandom_range(0, 49) == 0) step(1'b1, d);
                else                            step(1'b0, d);
            end
        end
        @(posedge CLK);
        @(posedge CLK);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain cyc=%0d got=%0d want=0", cyc, q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
